// File: rtl/ahb_cache_arbiter_2m_if.sv
// Signal bundle for the 2:1 AHB-Lite cache arbiter: two upstream master ports and one downstream slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface ahb_cache_arbiter_2m_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    // Handshake: an address phase is accepted on a rising edge where htrans[1] && hready are both high;
    // its data phase completes on the first later edge with hready high, and hresp there marks an error.
    logic              src0_hready;
    logic              src0_hready_resp;
    logic              src0_hresp;
    logic [W_ADDR-1:0] src0_haddr;
    logic              src0_hwrite;
    logic [1:0]        src0_htrans;
    logic [2:0]        src0_hsize;
    logic [3:0]        src0_hprot;
    logic              src0_hmastlock;
    logic [W_DATA-1:0] src0_hrdata;

    logic              src1_hready;
    logic              src1_hready_resp;
    logic              src1_hresp;
    logic [W_ADDR-1:0] src1_haddr;
    logic              src1_hwrite;
    logic [1:0]        src1_htrans;
    logic [2:0]        src1_hsize;
    logic [3:0]        src1_hprot;
    logic              src1_hmastlock;
    logic [W_DATA-1:0] src1_hrdata;

    logic              dst_hready;
    logic              dst_hready_resp;
    logic              dst_hresp;
    logic [W_ADDR-1:0] dst_haddr;
    logic              dst_hwrite;
    logic [1:0]        dst_htrans;
    logic [2:0]        dst_hsize;
    logic [2:0]        dst_hburst;
    logic [3:0]        dst_hprot;
    logic              dst_hmastlock;
    logic [W_DATA-1:0] dst_hrdata;

    modport slave (
        input  src0_hready, src0_haddr, src0_hwrite, src0_htrans, src0_hsize, src0_hprot, src0_hmastlock,
        output src0_hready_resp, src0_hresp, src0_hrdata,
        input  src1_hready, src1_haddr, src1_hwrite, src1_htrans, src1_hsize, src1_hprot, src1_hmastlock,
        output src1_hready_resp, src1_hresp, src1_hrdata,
        output dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock,
        input  dst_hready_resp, dst_hresp, dst_hrdata
    );

    modport master (
        output src0_hready, src0_haddr, src0_hwrite, src0_htrans, src0_hsize, src0_hprot, src0_hmastlock,
        input  src0_hready_resp, src0_hresp, src0_hrdata,
        output src1_hready, src1_haddr, src1_hwrite, src1_htrans, src1_hsize, src1_hprot, src1_hmastlock,
        input  src1_hready_resp, src1_hresp, src1_hrdata,
        input  dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock,
        output dst_hready_resp, dst_hresp, dst_hrdata
    );
endinterface

// File: rtl/ahb_cache_arbiter_2m.sv
// 2:1 AHB-Lite arbiter sharing one read-only cache slave port; losers are parked in a holding buffer.
// Optional master-lock support is enabled by defining CACHE_ARB_HMASTLOCK_EN.
module ahb_cache_arbiter_2m #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input logic                 clk,
    input logic                 rst,
    ahb_cache_arbiter_2m_if.slave bus
);
    localparam int W_CTRL = 8; // {hwrite, hsize[2:0], hprot[3:0]}

    logic [1:0]        live;
    logic [1:0]        cand;
    logic [1:0]        elig;
    logic [W_ADDR-1:0] in_addr [2];
    logic [W_CTRL-1:0] in_ctrl [2];

    logic [1:0]        pend_q, pend_d;
    logic [W_ADDR-1:0] hold_addr_q [2];
    logic [W_ADDR-1:0] hold_addr_d [2];
    logic [W_CTRL-1:0] hold_ctrl_q [2];
    logic [W_CTRL-1:0] hold_ctrl_d [2];
    logic              dph_valid_q, dph_valid_d;
    logic              dph_owner_q, dph_owner_d;
    logic              last_grant_q, last_grant_d;

    logic              issue;
    logic              win;
    logic [W_ADDR-1:0] sel_addr;
    logic [W_CTRL-1:0] sel_ctrl;
    logic [1:0]        hready_resp;
    logic [1:0]        hresp;
    logic [W_DATA-1:0] hrdata [2];

    always_comb begin
        live       = {bus.src1_hready && bus.src1_htrans[1], bus.src0_hready && bus.src0_htrans[1]};
        in_addr[0] = bus.src0_haddr;
        in_addr[1] = bus.src1_haddr;
        in_ctrl[0] = {bus.src0_hwrite, bus.src0_hsize, bus.src0_hprot};
        in_ctrl[1] = {bus.src1_hwrite, bus.src1_hsize, bus.src1_hprot};
    end

    // A master's own hready is low while it is parked, so pend and live never coincide per master.
    always_comb begin
        cand     = (pend_q | live) & elig;
        issue    = !rst && bus.dst_hready_resp && (cand != 2'b00);
        win      = (cand == 2'b11) ? ~last_grant_q : cand[1];
        sel_addr = pend_q[win] ? hold_addr_q[win] : in_addr[win];
        sel_ctrl = pend_q[win] ? hold_ctrl_q[win] : in_ctrl[win];
    end

    always_comb begin
        pend_d       = pend_q;
        hold_addr_d  = hold_addr_q;
        hold_ctrl_d  = hold_ctrl_q;
        dph_valid_d  = dph_valid_q;
        dph_owner_d  = dph_owner_q;
        last_grant_d = issue ? win : last_grant_q;
        for (int i = 0; i < 2; i++) begin
            if (issue && (win == 1'(i))) begin
                pend_d[i] = 1'b0;
            end else if (live[i]) begin
                pend_d[i]      = 1'b1;
                hold_addr_d[i] = in_addr[i];
                hold_ctrl_d[i] = in_ctrl[i];
            end
        end
        if (bus.dst_hready_resp) begin
            dph_valid_d = issue;
            dph_owner_d = win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= 2'b00;
            dph_valid_q  <= 1'b0;
            dph_owner_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            pend_q       <= pend_d;
            dph_valid_q  <= dph_valid_d;
            dph_owner_q  <= dph_owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_addr_q <= hold_addr_d;
        hold_ctrl_q <= hold_ctrl_d;
    end

`ifdef CACHE_ARB_HMASTLOCK_EN
    logic [1:0] in_lock;
    logic [1:0] hold_lock_q, hold_lock_d;
    logic       lock_active_q, lock_active_d;
    logic       lock_owner_q, lock_owner_d;
    logic       sel_lock;

    assign elig = {!lock_active_q || lock_owner_q, !lock_active_q || !lock_owner_q};

    always_comb begin
        in_lock       = {bus.src1_hmastlock, bus.src0_hmastlock};
        sel_lock      = pend_q[win] ? hold_lock_q[win] : in_lock[win];
        hold_lock_d   = hold_lock_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        for (int i = 0; i < 2; i++) begin
            if (live[i] && !(issue && (win == 1'(i)))) hold_lock_d[i] = in_lock[i];
        end
        // The lock is released only by an unlocked transfer from the lock holder itself.
        if (issue) begin
            if (sel_lock) begin
                lock_active_d = 1'b1;
                lock_owner_d  = win;
            end else if (lock_owner_q == win) begin
                lock_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_active_q <= 1'b0;
            lock_owner_q  <= 1'b0;
        end else begin
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
        end
        hold_lock_q <= hold_lock_d;
    end

    assign bus.dst_hmastlock = issue && sel_lock;
`else
    logic unused_lock;
    assign unused_lock       = bus.src0_hmastlock ^ bus.src1_hmastlock;
    assign elig              = 2'b11;
    assign bus.dst_hmastlock = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hready_resp[i] = pend_q[i] ? 1'b0 :
                             (dph_valid_q && (dph_owner_q == 1'(i))) ? bus.dst_hready_resp : 1'b1;
            hresp[i]       = dph_valid_q && (dph_owner_q == 1'(i)) && bus.dst_hresp;
            hrdata[i]      = (dph_valid_q && (dph_owner_q == 1'(i))) ? bus.dst_hrdata : '0;
        end
    end

    assign bus.src0_hready_resp = hready_resp[0];
    assign bus.src1_hready_resp = hready_resp[1];
    assign bus.src0_hresp       = hresp[0];
    assign bus.src1_hresp       = hresp[1];
    assign bus.src0_hrdata      = hrdata[0];
    assign bus.src1_hrdata      = hrdata[1];

    assign bus.dst_hready = bus.dst_hready_resp;
    assign bus.dst_haddr  = sel_addr;
    assign bus.dst_hwrite = sel_ctrl[7];
    assign bus.dst_hsize  = sel_ctrl[6:4];
    assign bus.dst_hprot  = sel_ctrl[3:0];
    assign bus.dst_hburst = 3'b000;
    assign bus.dst_htrans = issue ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_ahb_cache_arbiter_2m.sv
// Bench for ahb_cache_arbiter_2m: directed scenarios, then random traffic against a transaction-level
// model of two in-order masters and a downstream slave with random waits and address-keyed errors.
module tb_ahb_cache_arbiter_2m;
  localparam int W_ADDR = 32;
  localparam int W_DATA = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahb_cache_arbiter_2m_if #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) bus ();

  // Each master's bus hready is its own response (single master per upstream segment).
  assign bus.src0_hready = bus.src0_hready_resp;
  assign bus.src1_hready = bus.src1_hready_resp;

  ahb_cache_arbiter_2m #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp;
  int n_bad;

  // scoreboard: per-master upstream completions (exp) and downstream issue order (dq)
  logic [W_ADDR-1:0] exp_q0[$];
  logic [W_ADDR-1:0] exp_q1[$];
  logic [W_ADDR-1:0] dq0[$];
  logic [W_ADDR-1:0] dq1[$];

  logic [1:0]        m_busy;
  logic [W_ADDR-1:0] m_addr [2];
  logic              gen_en;
  logic              s_active;
  logic [W_ADDR-1:0] s_addr;
  int                s_wait;
  logic              s_err;
  logic              s_ph;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [W_DATA-1:0] slave_data(input logic [W_ADDR-1:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  function automatic logic slave_err(input logic [W_ADDR-1:0] a);
    return a[5:2] == 4'hF;
  endfunction

  function automatic int qsz(input int k);
    case (k)
      0: return exp_q0.size();
      1: return exp_q1.size();
      2: return dq0.size();
      default: return dq1.size();
    endcase
  endfunction

  function automatic logic [W_ADDR-1:0] qfront(input int k);
    case (k)
      0: return exp_q0[0];
      1: return exp_q1[0];
      2: return dq0[0];
      default: return dq1[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0: void'(exp_q0.pop_front());
      1: void'(exp_q1.pop_front());
      2: void'(dq0.pop_front());
      default: void'(dq1.pop_front());
    endcase
  endtask

  task automatic qpush(input int k, input logic [W_ADDR-1:0] v);
    case (k)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      2: dq0.push_back(v);
      default: dq1.push_back(v);
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_src(input int i, input logic [1:0] t, input logic [W_ADDR-1:0] a, input logic lk);
    if (i == 0) begin
      bus.src0_htrans = t; bus.src0_haddr = a; bus.src0_hwrite = 1'b0;
      bus.src0_hsize = 3'b010; bus.src0_hprot = 4'b0010; bus.src0_hmastlock = lk;
    end else begin
      bus.src1_htrans = t; bus.src1_haddr = a; bus.src1_hwrite = 1'b0;
      bus.src1_hsize = 3'b010; bus.src1_hprot = 4'b0011; bus.src1_hmastlock = lk;
    end
  endtask

  task automatic set_dst(input logic rdy, input logic rsp, input logic [W_DATA-1:0] d);
    bus.dst_hready_resp = rdy;
    bus.dst_hresp       = rsp;
    bus.dst_hrdata      = d;
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic rand_drive();
    if (s_active) begin
      if (s_wait > 0) begin
        set_dst(1'b0, 1'b0, $urandom);
        s_wait--;
      end else if (s_err && !s_ph) begin
        set_dst(1'b0, 1'b1, $urandom);
        s_ph = 1'b1;
      end else begin
        set_dst(1'b1, s_err, s_err ? $urandom : slave_data(s_addr));
      end
    end else begin
      set_dst(1'b1, 1'b0, $urandom);
    end
    for (int i = 0; i < 2; i++) begin
      if (!m_busy[i] && gen_en && ($urandom_range(0, 9) < 6)) begin
        m_busy[i] = 1'b1;
        m_addr[i] = {19'd0, 1'(i), 10'($urandom), 2'b00};
      end
      set_src(i, m_busy[i] ? 2'b10 : 2'b00, m_busy[i] ? m_addr[i] : W_ADDR'($urandom), 1'b0);
    end
  endtask

  task automatic rand_sample();
    logic [1:0]        rdy;
    logic [1:0]        rsp;
    logic [W_DATA-1:0] rd [2];
    logic [W_ADDR-1:0] a;
    int                id;
    rdy   = {bus.src1_hready_resp, bus.src0_hready_resp};
    rsp   = {bus.src1_hresp, bus.src0_hresp};
    rd[0] = bus.src0_hrdata;
    rd[1] = bus.src1_hrdata;
    for (int i = 0; i < 2; i++) begin
      if (qsz(i) > 0) begin
        if (rdy[i]) begin
          a = qfront(i);
          check_eq("src_hresp", 32'(rsp[i]), 32'(slave_err(a)));
          if (!slave_err(a)) check_eq("src_hrdata", rd[i], slave_data(a));
          qpop(i);
        end
      end else begin
        check_eq("idle_hresp", 32'(rsp[i]), 32'd0);
        check_eq("idle_hrdata", rd[i], 32'd0);
      end
      if (m_busy[i] && rdy[i]) begin
        qpush(i, m_addr[i]);
        qpush(i + 2, m_addr[i]);
        m_busy[i] = 1'b0;
      end
    end
    if (s_active && bus.dst_hready_resp) s_active = 1'b0;
    if (bus.dst_htrans != 2'b00) begin
      check_eq("dst_htrans", 32'(bus.dst_htrans), 32'd2);
      check_eq("nseq_in_wait", 32'(bus.dst_hready_resp), 32'd1);
    end
    if (bus.dst_htrans == 2'b10 && bus.dst_hready_resp) begin
      id = int'(bus.dst_haddr[12]);
      if (qsz(id + 2) == 0) begin
        check_eq("dst_unexpected", 32'(qsz(id + 2)), 32'd1);
      end else begin
        check_eq("dst_haddr", bus.dst_haddr, qfront(id + 2));
        check_eq("dst_hprot", 32'(bus.dst_hprot), 32'(id) | 32'd2);
        check_eq("dst_hsize", 32'(bus.dst_hsize), 32'd2);
        check_eq("dst_hburst", 32'(bus.dst_hburst), 32'd0);
        qpop(id + 2);
      end
      s_active = 1'b1;
      s_addr   = bus.dst_haddr;
      s_wait   = $urandom_range(0, 2);
      s_err    = slave_err(bus.dst_haddr);
      s_ph     = 1'b0;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_busy = 2'b00;
    gen_en = 1'b0;
    s_active = 1'b0;
    s_addr = '0;
    s_wait = 0;
    s_err = 1'b0;
    s_ph = 1'b0;
    m_addr[0] = '0;
    m_addr[1] = '0;

    // ---- reset ----
    rst = 1'b1;
    set_src(0, 2'b00, 32'h0, 1'b0);
    set_src(1, 2'b00, 32'h0, 1'b0);
    set_dst(1'b1, 1'b0, 32'hDEAD_BEEF);
    repeat (3) @(posedge clk);
    to_sample();
    check_eq("rst_src0_hready", 32'(bus.src0_hready_resp), 32'd1);
    check_eq("rst_src1_hready", 32'(bus.src1_hready_resp), 32'd1);
    check_eq("rst_src0_hresp", 32'(bus.src0_hresp), 32'd0);
    check_eq("rst_src1_hresp", 32'(bus.src1_hresp), 32'd0);
    check_eq("rst_src0_hrdata", bus.src0_hrdata, 32'd0);
    check_eq("rst_src1_hrdata", bus.src1_hrdata, 32'd0);
    check_eq("rst_dst_htrans", 32'(bus.dst_htrans), 32'd0);
    check_eq("rst_dst_hmastlock", 32'(bus.dst_hmastlock), 32'd0);
    next_drive();
    rst = 1'b0;

    // ---- tie after reset: src0 first, src1 from buffer one cycle later ----
    set_src(0, 2'b10, 32'h100, 1'b0);
    set_src(1, 2'b10, 32'h204, 1'b0);
    to_sample();
    check_eq("tie_htrans", 32'(bus.dst_htrans), 32'd2);
    check_eq("tie_haddr0", bus.dst_haddr, 32'h100);
    check_eq("tie_src1_acc", 32'(bus.src1_hready_resp), 32'd1);
    next_drive();
    set_src(0, 2'b00, 32'h0, 1'b0);
    set_src(1, 2'b00, 32'h0, 1'b0);
    set_dst(1'b1, 1'b0, 32'hAAAA_0100);
    to_sample();
    check_eq("buf_htrans", 32'(bus.dst_htrans), 32'd2);
    check_eq("buf_haddr", bus.dst_haddr, 32'h204);
    check_eq("buf_src1_hready", 32'(bus.src1_hready_resp), 32'd0);
    check_eq("buf_src0_hready", 32'(bus.src0_hready_resp), 32'd1);
    check_eq("buf_src0_hrdata", bus.src0_hrdata, 32'hAAAA_0100);
    check_eq("buf_src1_hrdata", bus.src1_hrdata, 32'd0);
    next_drive();
    set_dst(1'b1, 1'b0, 32'hBBBB_0204);
    to_sample();
    check_eq("buf_src1_done", 32'(bus.src1_hready_resp), 32'd1);
    check_eq("buf_src1_hrdata", bus.src1_hrdata, 32'hBBBB_0204);
    check_eq("buf_idle", 32'(bus.dst_htrans), 32'd0);
    next_drive();
    set_src(0, 2'b10, 32'h108, 1'b0);
    set_src(1, 2'b10, 32'h20C, 1'b0);
    to_sample();
    check_eq("tie2_haddr", bus.dst_haddr, 32'h108);
    next_drive();
    set_src(0, 2'b00, 32'h0, 1'b0);
    set_src(1, 2'b00, 32'h0, 1'b0);
    to_sample();
    check_eq("tie2_haddr_buf", bus.dst_haddr, 32'h20C);
    check_eq("tie2_htrans_buf", 32'(bus.dst_htrans), 32'd2);
    next_drive();
    to_sample();
    check_eq("tie2_idle", 32'(bus.dst_htrans), 32'd0);

    // ---- uncontended zero-latency read ----
    next_drive();
    set_src(0, 2'b10, 32'h100, 1'b0);
    to_sample();
    check_eq("unc_htrans", 32'(bus.dst_htrans), 32'd2);
    check_eq("unc_haddr", bus.dst_haddr, 32'h100);
    check_eq("unc_hprot", 32'(bus.dst_hprot), 32'd2);
    next_drive();
    set_src(0, 2'b00, 32'h0, 1'b0);
    set_dst(1'b1, 1'b0, 32'h1111);
    to_sample();
    check_eq("unc_src0_hready", 32'(bus.src0_hready_resp), 32'd1);
    check_eq("unc_src0_hrdata", bus.src0_hrdata, 32'h1111);
    check_eq("unc_src1_hrdata", bus.src1_hrdata, 32'd0);

    // ---- three downstream wait states on src0, src1 parked meanwhile ----
    next_drive();
    set_src(0, 2'b10, 32'h300, 1'b0);
    to_sample();
    check_eq("ws_haddr0", bus.dst_haddr, 32'h300);
    next_drive();
    set_src(0, 2'b00, 32'h0, 1'b0);
    set_src(1, 2'b10, 32'h400, 1'b0);
    set_dst(1'b0, 1'b0, 32'h0);
    to_sample();
    check_eq("ws1_htrans", 32'(bus.dst_htrans), 32'd0);
    check_eq("ws1_src0_hready", 32'(bus.src0_hready_resp), 32'd0);
    check_eq("ws1_src1_acc", 32'(bus.src1_hready_resp), 32'd1);
    next_drive();
    set_src(1, 2'b00, 32'h0, 1'b0);
    to_sample();
    check_eq("ws2_htrans", 32'(bus.dst_htrans), 32'd0);
    check_eq("ws2_src1_pend", 32'(bus.src1_hready_resp), 32'd0);
    next_drive();
    to_sample();
    check_eq("ws3_htrans", 32'(bus.dst_htrans), 32'd0);
    next_drive();
    set_dst(1'b1, 1'b0, 32'h3333);
    to_sample();
    check_eq("ws_issue_htrans", 32'(bus.dst_htrans), 32'd2);
    check_eq("ws_issue_haddr", bus.dst_haddr, 32'h400);
    check_eq("ws_src0_hrdata", bus.src0_hrdata, 32'h3333);
    check_eq("ws_src0_hready", 32'(bus.src0_hready_resp), 32'd1);
    next_drive();
    set_dst(1'b1, 1'b0, 32'h4444);
    to_sample();
    check_eq("ws_src1_hready", 32'(bus.src1_hready_resp), 32'd1);
    check_eq("ws_src1_hrdata", bus.src1_hrdata, 32'h4444);

    // ---- two-phase error on src1, src0 unaffected ----
    next_drive();
    set_src(1, 2'b10, 32'h500, 1'b0);
    to_sample();
    check_eq("err_haddr", bus.dst_haddr, 32'h500);
    next_drive();
    set_src(1, 2'b00, 32'h0, 1'b0);
    set_src(0, 2'b10, 32'h600, 1'b0);
    set_dst(1'b0, 1'b1, 32'h0);
    to_sample();
    check_eq("err_ph0_hresp", 32'(bus.src1_hresp), 32'd1);
    check_eq("err_ph0_hready", 32'(bus.src1_hready_resp), 32'd0);
    check_eq("err_ph0_src0_hresp", 32'(bus.src0_hresp), 32'd0);
    check_eq("err_ph0_htrans", 32'(bus.dst_htrans), 32'd0);
    next_drive();
    set_src(0, 2'b00, 32'h0, 1'b0);
    set_dst(1'b1, 1'b1, 32'h0);
    to_sample();
    check_eq("err_ph1_hresp", 32'(bus.src1_hresp), 32'd1);
    check_eq("err_ph1_hready", 32'(bus.src1_hready_resp), 32'd1);
    check_eq("err_ph1_src0_hresp", 32'(bus.src0_hresp), 32'd0);
    check_eq("err_ph1_htrans", 32'(bus.dst_htrans), 32'd2);
    check_eq("err_ph1_haddr", bus.dst_haddr, 32'h600);
    next_drive();
    set_dst(1'b1, 1'b0, 32'h6666);
    to_sample();
    check_eq("err_src0_hready", 32'(bus.src0_hready_resp), 32'd1);
    check_eq("err_src0_hresp", 32'(bus.src0_hresp), 32'd0);
    check_eq("err_src0_hrdata", bus.src0_hrdata, 32'h6666);
    check_eq("err_src1_clear", 32'(bus.src1_hresp), 32'd0);

    // ---- reset with src1 parked and src0 in data phase ----
    next_drive();
    set_src(0, 2'b10, 32'h700, 1'b0);
    set_dst(1'b1, 1'b0, 32'h0);
    to_sample();
    check_eq("rst2_haddr", bus.dst_haddr, 32'h700);
    next_drive();
    set_src(0, 2'b00, 32'h0, 1'b0);
    set_src(1, 2'b10, 32'h800, 1'b0);
    set_dst(1'b0, 1'b0, 32'h7777);
    to_sample();
    check_eq("rst2_src1_acc", 32'(bus.src1_hready_resp), 32'd1);
    next_drive();
    set_src(1, 2'b00, 32'h0, 1'b0);
    rst = 1'b1;
    next_drive();
    rst = 1'b0;
    set_dst(1'b1, 1'b0, 32'h9999);
    to_sample();
    check_eq("rst2_src0_hready", 32'(bus.src0_hready_resp), 32'd1);
    check_eq("rst2_src1_hready", 32'(bus.src1_hready_resp), 32'd1);
    check_eq("rst2_src0_hrdata", bus.src0_hrdata, 32'd0);
    check_eq("rst2_src1_hrdata", bus.src1_hrdata, 32'd0);
    check_eq("rst2_src0_hresp", 32'(bus.src0_hresp), 32'd0);
    check_eq("rst2_htrans", 32'(bus.dst_htrans), 32'd0);

`ifdef CACHE_ARB_HMASTLOCK_EN
    // ---- locked sequence from src0 holds src1 off ----
    next_drive();
    set_src(0, 2'b10, 32'h900, 1'b1);
    set_src(1, 2'b10, 32'hA00, 1'b0);
    to_sample();
    check_eq("lock1_haddr", bus.dst_haddr, 32'h900);
    check_eq("lock1_hmastlock", 32'(bus.dst_hmastlock), 32'd1);
    next_drive();
    set_src(0, 2'b10, 32'h904, 1'b1);
    set_src(1, 2'b00, 32'h0, 1'b0);
    to_sample();
    check_eq("lock2_haddr", bus.dst_haddr, 32'h904);
    next_drive();
    set_src(0, 2'b10, 32'h908, 1'b0);
    to_sample();
    check_eq("lock3_haddr", bus.dst_haddr, 32'h908);
    check_eq("lock3_hmastlock", 32'(bus.dst_hmastlock), 32'd0);
    next_drive();
    set_src(0, 2'b00, 32'h0, 1'b0);
    to_sample();
    check_eq("lock_src1_haddr", bus.dst_haddr, 32'hA00);
    check_eq("lock_src1_htrans", 32'(bus.dst_htrans), 32'd2);
    next_drive();
    to_sample();
`endif

    // ---- random traffic ----
    gen_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      next_drive();
      rand_drive();
      to_sample();
      rand_sample();
    end
    gen_en = 1'b0;
    for (int c = 0; c < 60; c++) begin
      next_drive();
      rand_drive();
      to_sample();
      rand_sample();
    end
    check_eq("drain_src0", 32'(qsz(0)), 32'd0);
    check_eq("drain_src1", 32'(qsz(1)), 32'd0);
    check_eq("drain_dst0", 32'(qsz(2)), 32'd0);
    check_eq("drain_dst1", 32'(qsz(3)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
